// File: rtl/score_sequencer.sv
// Score fetch/decode sequencer: fetches 16-bit score words, runs BPM/REPEAT/END
// in hardware and hands BPM-tagged notes to a player through a FWFT FIFO.
module score_sequencer #(
    parameter int                ADDR_W      = 18,
    parameter logic [ADDR_W-1:0] START_ADDR  = ADDR_W'(18'h0FF00),
    parameter int                REP_DEPTH   = 4,
    parameter int                REP_CNT_W   = 8,
    parameter int                FIFO_DEPTH  = 4,
    parameter int                DEFAULT_BPM = 96
) (
    input  logic                               CLK,
    input  logic                               RESET_N,
    input  logic                               START,
    input  logic                               PAUSE,
    output logic                               MEM_REQ,
    output logic [ADDR_W-1:0]                  MEM_ADDR,
    input  logic                               MEM_ACK,
    input  logic [15:0]                        MEM_DATA,
    output logic                               NOTE_VALID,
    input  logic                               NOTE_READY,
    output logic [15:0]                        NOTE_INS,
    output logic [11:0]                        NOTE_BPM,
    output logic                               BUSY,
    output logic                               DONE,
    output logic                               ERR_OVF,
    output logic                               ERR_UNF,
    output logic [$clog2(REP_DEPTH+1)-1:0]     REP_LEVEL
);

    // state   | meaning
    // sIdle   | after reset, waiting for START
    // sReq    | fetching the word at pc (request held until MEM_ACK)
    // sDecode | executing ir; a note waits here while the FIFO is full
    // sDrain  | END or error seen, waiting for the FIFO to empty
    // sDone   | finished, DONE high until the next START
    typedef enum logic [2:0] {sIdle, sReq, sDecode, sDrain, sDone} stateType;

    localparam int SP_W  = $clog2(REP_DEPTH + 1);
    localparam int IDX_W = (REP_DEPTH > 1) ? $clog2(REP_DEPTH) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    stateType              state;
    logic [ADDR_W-1:0]     pc;
    logic [11:0]           bpm;
    logic [15:0]           ir;
    logic [SP_W-1:0]       sp;
    logic                  memReq;
    logic                  errOvf;
    logic                  errUnf;
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [CNT_W-1:0]      fifoCount;
    logic [ADDR_W-1:0]     stackAddr [REP_DEPTH];
    logic [REP_CNT_W-1:0]  stackCnt  [REP_DEPTH];
    logic [15:0]           fifoIns   [FIFO_DEPTH];
    logic [11:0]           fifoBpm   [FIFO_DEPTH];

    logic                  fifoFull;
    logic                  noteValid;
    logic                  push;
    logic                  pop;
    logic [ADDR_W-1:0]     pcNext;
    logic [IDX_W-1:0]      topIdx;
    logic [IDX_W-1:0]      pushIdx;
    logic [REP_CNT_W-1:0]  repCnt;

    assign fifoFull  = (fifoCount == CNT_W'(FIFO_DEPTH));
    assign noteValid = (fifoCount != '0);
    assign pop       = noteValid && NOTE_READY;
    // Full is judged before the same-cycle pop, costing one bubble when full.
    assign push      = (state == sDecode) && ir[15] && !fifoFull;
    assign pcNext    = pc + 1'b1;
    assign topIdx    = IDX_W'(sp - 1'b1);
    assign pushIdx   = IDX_W'(sp);
    assign repCnt    = (ir[REP_CNT_W-1:0] == '0) ? REP_CNT_W'(1) : ir[REP_CNT_W-1:0];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= sIdle;
            pc        <= START_ADDR;
            bpm       <= 12'(DEFAULT_BPM);
            ir        <= '0;
            sp        <= '0;
            memReq    <= 1'b0;
            errOvf    <= 1'b0;
            errUnf    <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            for (int i = 0; i < REP_DEPTH; i++) begin
                stackAddr[i] <= '0;
                stackCnt[i]  <= '0;
            end
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase

            case (state)
                sIdle, sDone: begin
                    if (START) begin
                        pc        <= START_ADDR;
                        bpm       <= 12'(DEFAULT_BPM);
                        sp        <= '0;
                        errOvf    <= 1'b0;
                        errUnf    <= 1'b0;
                        wrPtr     <= '0;
                        rdPtr     <= '0;
                        fifoCount <= '0;
                        memReq    <= !PAUSE;
                        state     <= sReq;
                    end
                end
                sReq: begin
                    if (memReq && MEM_ACK) begin
                        ir     <= MEM_DATA;
                        memReq <= 1'b0;
                        state  <= sDecode;
                    end else if (!memReq && !PAUSE) begin
                        memReq <= 1'b1;
                    end
                end
                sDecode: begin
                    if (ir[15]) begin
                        if (!fifoFull) begin
                            pc     <= pcNext;
                            memReq <= !PAUSE;
                            state  <= sReq;
                        end
                    end else begin
                        case (ir[14:12])
                            3'b000: state <= sDrain;
                            3'b001: begin
                                if (ir[11:0] != '0) bpm <= ir[11:0];
                                pc     <= pcNext;
                                memReq <= !PAUSE;
                                state  <= sReq;
                            end
                            3'b010: begin
                                if (sp == SP_W'(REP_DEPTH)) begin
                                    errOvf <= 1'b1;
                                    state  <= sDrain;
                                end else begin
                                    stackAddr[pushIdx] <= pcNext;
                                    stackCnt[pushIdx]  <= repCnt;
                                    sp     <= sp + 1'b1;
                                    pc     <= pcNext;
                                    memReq <= !PAUSE;
                                    state  <= sReq;
                                end
                            end
                            3'b011: begin
                                if (sp == '0) begin
                                    errUnf <= 1'b1;
                                    state  <= sDrain;
                                end else begin
                                    // Count is total plays, so the last pass pops instead of looping.
                                    if (stackCnt[topIdx] > REP_CNT_W'(1)) begin
                                        stackCnt[topIdx] <= stackCnt[topIdx] - 1'b1;
                                        pc <= stackAddr[topIdx];
                                    end else begin
                                        sp <= sp - 1'b1;
                                        pc <= pcNext;
                                    end
                                    memReq <= !PAUSE;
                                    state  <= sReq;
                                end
                            end
                            default: begin
                                pc     <= pcNext;
                                memReq <= !PAUSE;
                                state  <= sReq;
                            end
                        endcase
                    end
                end
                sDrain: begin
                    if (fifoCount == '0) state <= sDone;
                end
                default: state <= sIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifoIns[wrPtr] <= ir;
            fifoBpm[wrPtr] <= bpm;
        end
    end

    assign MEM_REQ    = memReq;
    assign MEM_ADDR   = pc;
    assign NOTE_VALID = noteValid;
    assign NOTE_INS   = noteValid ? fifoIns[rdPtr] : '0;
    assign NOTE_BPM   = noteValid ? fifoBpm[rdPtr] : '0;
    assign BUSY       = (state == sReq) || (state == sDecode) || (state == sDrain);
    assign DONE       = (state == sDone);
    assign ERR_OVF    = errOvf;
    assign ERR_UNF    = errUnf;
    assign REP_LEVEL  = sp;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer: a memory responder feeds score words and a
// note scoreboard compares every delivered note against the expected sequence.
module tb_score_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic        PAUSE;
    logic        MEM_REQ;
    logic [17:0] MEM_ADDR;
    logic        MEM_ACK = 1'b0;
    logic [15:0] MEM_DATA = '0;
    logic        NOTE_VALID;
    logic        NOTE_READY;
    logic [15:0] NOTE_INS;
    logic [11:0] NOTE_BPM;
    logic        BUSY;
    logic        DONE;
    logic        ERR_OVF;
    logic        ERR_UNF;
    logic [1:0]  REP_LEVEL;

    score_sequencer #(.REP_DEPTH(2)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .PAUSE(PAUSE),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
        .NOTE_VALID(NOTE_VALID), .NOTE_READY(NOTE_READY), .NOTE_INS(NOTE_INS),
        .NOTE_BPM(NOTE_BPM), .BUSY(BUSY), .DONE(DONE), .ERR_OVF(ERR_OVF),
        .ERR_UNF(ERR_UNF), .REP_LEVEL(REP_LEVEL)
    );

    always #5 CLK = ~CLK;

    int          passCnt = 0;
    int          totalCnt = 0;
    logic [15:0] memWords [256];
    int          fetchCnt [256];
    int          fetchTotal = 0;
    logic [17:0] firstFetch = '0;
    logic        ackHold = 1'b0;
    logic        forceAck = 1'b0;
    int          maxLevel = 0;
    logic [27:0] expQ [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Memory responder: acks one cycle after the request, unless held.
    always @(negedge CLK) begin
        if (MEM_REQ && !MEM_ACK && !ackHold) begin
            if (fetchTotal == 0) firstFetch = MEM_ADDR;
            fetchCnt[MEM_ADDR[7:0]]++;
            fetchTotal++;
            MEM_DATA = memWords[MEM_ADDR[7:0]];
            MEM_ACK  = 1'b1;
        end else if (forceAck) begin
            MEM_DATA = 16'h8FFF;
            MEM_ACK  = 1'b1;
        end else begin
            MEM_ACK  = 1'b0;
        end
    end

    // Note scoreboard and repeat-depth tracker.
    always @(negedge CLK) begin
        if (int'(REP_LEVEL) > maxLevel) maxLevel = int'(REP_LEVEL);
        if (NOTE_VALID && NOTE_READY) begin
            if (expQ.size() == 0) begin
                check("unexpected note", {12'h0, 4'h0, NOTE_INS}, 32'hFFFF_FFFF);
            end else begin
                logic [27:0] e;
                e = expQ.pop_front();
                check("note ins", 32'(NOTE_INS), 32'(e[27:12]));
                check("note bpm", 32'(NOTE_BPM), 32'(e[11:0]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) begin
            memWords[i] = 16'h0000;
            fetchCnt[i] = 0;
        end
        fetchTotal = 0;
        maxLevel   = 0;
    endtask

    task automatic pulseStart();
        step(1);
        START = 1'b1;
        step(1);
        START = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        for (int i = 0; i < budget && !DONE; i++) step(1);
        check(tag, 32'(DONE), 32'd1);
    endtask

    task automatic expNote(input logic [15:0] ins, input logic [11:0] b);
        expQ.push_back({ins, b});
    endtask

    task automatic loadNested();
        memWords[0] = 16'h1078; memWords[1] = 16'h2002; memWords[2] = 16'h2003;
        memWords[3] = 16'h8001; memWords[4] = 16'h3000; memWords[5] = 16'h8002;
        memWords[6] = 16'h3000; memWords[7] = 16'h0000;
    endtask

    task automatic expNested();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) expNote(16'h8001, 12'd120);
            expNote(16'h8002, 12'd120);
        end
    endtask

    initial begin
        RESET_N = 1'b0; START = 1'b0; PAUSE = 1'b0; NOTE_READY = 1'b1;
        clearMem();
        step(3);
        check("rst mem_req",   32'(MEM_REQ),    32'd0);
        check("rst mem_addr",  32'(MEM_ADDR),   32'h0FF00);
        check("rst outputs",   {26'h0, NOTE_VALID, BUSY, DONE, ERR_OVF, ERR_UNF, 1'b0}, 32'd0);
        check("rst note",      {4'h0, NOTE_INS, NOTE_BPM}, 32'd0);
        check("rst rep_level", 32'(REP_LEVEL),  32'd0);
        RESET_N = 1'b1;
        step(2);

        // Linear play
        clearMem();
        memWords[0] = 16'h8123; memWords[1] = 16'h8456; memWords[2] = 16'h0000;
        expNote(16'h8123, 12'd96);
        expNote(16'h8456, 12'd96);
        pulseStart();
        check("lin busy", 32'(BUSY), 32'd1);
        waitDone("lin done", 200);
        check("lin notes left", 32'(expQ.size()), 32'd0);
        for (int a = 0; a < 3; a++) check("lin fetch once", 32'(fetchCnt[a]), 32'd1);
        check("lin fetch total", 32'(fetchTotal), 32'd3);
        check("lin busy end", 32'(BUSY), 32'd0);

        // BPM and nested repeat
        clearMem();
        loadNested();
        expNested();
        pulseStart();
        waitDone("nest done", 500);
        check("nest notes left", 32'(expQ.size()), 32'd0);
        check("nest max level", 32'(maxLevel), 32'd2);
        check("nest end level", 32'(REP_LEVEL), 32'd0);
        check("nest errs", {30'h0, ERR_OVF, ERR_UNF}, 32'd0);

        // Overflow with depth 2
        clearMem();
        memWords[0] = 16'h8011; memWords[1] = 16'h2002; memWords[2] = 16'h2002;
        memWords[3] = 16'h2002; memWords[4] = 16'h8022;
        expNote(16'h8011, 12'd96);
        pulseStart();
        waitDone("ovf done", 200);
        check("ovf flag", 32'(ERR_OVF), 32'd1);
        check("ovf unf clear", 32'(ERR_UNF), 32'd0);
        check("ovf fetch total", 32'(fetchTotal), 32'd4);
        check("ovf no fetch after", 32'(fetchCnt[4]), 32'd0);
        check("ovf level", 32'(REP_LEVEL), 32'd2);
        check("ovf notes left", 32'(expQ.size()), 32'd0);

        // Underflow, then a START clears the error bits
        clearMem();
        memWords[0] = 16'h8001; memWords[1] = 16'h3000;
        expNote(16'h8001, 12'd96);
        pulseStart();
        check("unf ovf cleared", 32'(ERR_OVF), 32'd0);
        waitDone("unf done", 200);
        check("unf flag", 32'(ERR_UNF), 32'd1);
        check("unf notes left", 32'(expQ.size()), 32'd0);
        clearMem();
        pulseStart();
        check("unf cleared by start", {30'h0, ERR_OVF, ERR_UNF}, 32'd0);
        waitDone("unf restart done", 200);
        check("unf stays clear", {30'h0, ERR_OVF, ERR_UNF}, 32'd0);

        // Backpressure: FIFO fills, fifth note held in decode
        clearMem();
        for (int k = 0; k < 6; k++) begin
            memWords[k] = 16'h8101 + 16'(k);
            expNote(16'h8101 + 16'(k), 12'd96);
        end
        NOTE_READY = 1'b0;
        pulseStart();
        step(40);
        check("bp fetch total", 32'(fetchTotal), 32'd5);
        check("bp mem_req low", 32'(MEM_REQ), 32'd0);
        check("bp head", 32'(NOTE_INS), 32'h8101);
        check("bp valid", 32'(NOTE_VALID), 32'd1);
        step(10);
        check("bp still held", 32'(fetchTotal), 32'd5);
        check("bp head stable", 32'(NOTE_INS), 32'h8101);
        NOTE_READY = 1'b1;
        waitDone("bp done", 300);
        check("bp notes left", 32'(expQ.size()), 32'd0);
        check("bp fetch final", 32'(fetchTotal), 32'd7);

        // PAUSE while a request is outstanding
        clearMem();
        memWords[0] = 16'h8201; memWords[1] = 16'h8202; memWords[2] = 16'h0000;
        expNote(16'h8201, 12'd96);
        expNote(16'h8202, 12'd96);
        ackHold = 1'b1;
        pulseStart();
        for (int i = 0; i < 20 && !MEM_REQ; i++) step(1);
        check("pause req up", 32'(MEM_REQ), 32'd1);
        PAUSE = 1'b1;
        step(3);
        check("pause req held", 32'(MEM_REQ), 32'd1);
        check("pause addr held", 32'(MEM_ADDR), 32'h0FF00);
        ackHold = 1'b0;
        step(8);
        check("pause no new req", 32'(MEM_REQ), 32'd0);
        check("pause one fetch", 32'(fetchTotal), 32'd1);
        check("pause busy", 32'(BUSY), 32'd1);
        PAUSE = 1'b0;
        waitDone("pause done", 200);
        check("pause notes left", 32'(expQ.size()), 32'd0);
        check("pause fetch total", 32'(fetchTotal), 32'd3);

        // Reset in the middle of a nested repeat, then replay
        clearMem();
        loadNested();
        expNested();
        pulseStart();
        for (int i = 0; i < 100 && REP_LEVEL != 2'd2; i++) step(1);
        check("mid level 2", 32'(REP_LEVEL), 32'd2);
        RESET_N = 1'b0;
        #1;
        expQ.delete();
        check("mid rst outputs", {24'h0, MEM_REQ, NOTE_VALID, BUSY, DONE, ERR_OVF, ERR_UNF, REP_LEVEL}, 32'd0);
        check("mid rst note", {4'h0, NOTE_INS, NOTE_BPM}, 32'd0);
        check("mid rst addr", 32'(MEM_ADDR), 32'h0FF00);
        step(2);
        RESET_N = 1'b1;
        step(1);
        forceAck = 1'b1;
        step(1);
        forceAck = 1'b0;
        step(2);
        check("late ack ignored", {30'h0, BUSY, MEM_REQ}, 32'd0);
        clearMem();
        loadNested();
        expNested();
        pulseStart();
        check("replay level 0", 32'(REP_LEVEL), 32'd0);
        waitDone("replay done", 500);
        check("replay first addr", 32'(firstFetch), 32'h0FF00);
        check("replay notes left", 32'(expQ.size()), 32'd0);
        check("replay max level", 32'(maxLevel), 32'd2);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/score_sequencer.md
Name: score_sequencer

Overview:
- Parametrised successor to the single-voice music CPU fetch/decode path.
- Fetches 16-bit score instructions from external memory over a request/acknowledge handshake, then executes BPM and END instructions.
- Adds a hardware repeat stack with configurable nesting depth.
- Buffers decoded notes, each tagged with its BPM, in a prefetch FIFO. A downstream tone/duration player drains the FIFO through a valid/ready handshake.

Parameters:
- ADDR_W, 18, memory address width.
- START_ADDR, 18'h0FF00, first instruction address on START.
- REP_DEPTH, 4, maximum repeat nesting depth (≥1).
- REP_CNT_W, 8, repeat count width.
- FIFO_DEPTH, 4, note FIFO entries (power of two, ≥2).
- DEFAULT_BPM, 96, BPM loaded on reset and on START.

Ports:
- CLK, in, 1: system clock.
- RESET_N, in, 1: asynchronous, active-low reset.
- START, in, 1: single-cycle pulse; begins playback.
- PAUSE, in, 1: level; blocks issue of new fetches.
- MEM_REQ, out, 1: read request.
- MEM_ADDR, out, ADDR_W: read address.
- MEM_ACK, in, 1: read acknowledge; MEM_DATA is valid in the same cycle.
- MEM_DATA, in, 16: instruction word.
- NOTE_VALID, out, 1: FIFO non-empty.
- NOTE_READY, in, 1: consumer accepts the head entry.
- NOTE_INS, out, 16: note instruction at the FIFO head.
- NOTE_BPM, out, 12: BPM in effect when that note was decoded.
- BUSY, out, 1: state is neither IDLE nor DONE.
- DONE, out, 1: END executed and FIFO drained.
- ERR_OVF, out, 1: sticky; repeat stack overflow.
- ERR_UNF, out, 1: sticky; repeat END with empty stack.
- REP_LEVEL, out, $clog2(REP_DEPTH+1): current stack depth.

Behaviour:
- Reset (async assert, sync release): state IDLE; pc=START_ADDR; bpm=DEFAULT_BPM; sp=0; FIFO empty. All outputs 0, except MEM_ADDR=START_ADDR.
- States: IDLE, REQ, DECODE, DRAIN, DONE.
- IDLE/DONE + START:
  - pc=START_ADDR, bpm=DEFAULT_BPM, sp=0.
  - ERR_* cleared, FIFO flushed, DONE cleared.
  - Next state REQ.
  - START is ignored in every other state.
- REQ:
  - MEM_REQ=1 with MEM_ADDR=pc, unless PAUSE is high while no request is outstanding.
  - Once raised, MEM_REQ and MEM_ADDR stay stable until MEM_ACK, even if PAUSE rises.
  - On MEM_ACK: latch MEM_DATA into ir, drop MEM_REQ the next cycle, go to DECODE.
- DECODE, one cycle per instruction, except a note held by a full FIFO:
  - ir[15]=1 (note):
    - FIFO full → hold in DECODE.
    - Otherwise push {ir, bpm}, pc+1, go to REQ.
    - Full is sampled before the same-cycle pop, so a push to a full FIFO costs one bubble cycle.
  - ir[15:12]=0001 (BPM):
    - bpm=ir[11:0] if nonzero; 0 leaves bpm unchanged.
    - pc+1, go to REQ. Notes decoded after this instruction carry the new bpm.
  - ir[15:12]=0010 (REPEAT_START), cnt=ir[REP_CNT_W-1:0], where cnt=0 is treated as 1:
    - sp==REP_DEPTH → ERR_OVF=1, go to DRAIN.
    - Otherwise push {pc+1, cnt}, sp+1, pc+1, go to REQ.
  - ir[15:12]=0011 (REPEAT_END):
    - sp==0 → ERR_UNF=1, go to DRAIN.
    - top.cnt>1 → top.cnt-1, pc=top.addr.
    - top.cnt==1 → pop (sp-1), pc+1.
    - In all non-error cases go to REQ.
    - cnt is the total number of times the body plays.
  - ir[15:12]=0000 (END): go to DRAIN.
  - ir[15:12]=01xx (reserved): skipped, pc+1, go to REQ.
- pc increment wraps from 2^ADDR_W-1 to 0.
- DRAIN: no fetches; when the FIFO is empty → DONE. DONE=1 while in DONE.
- FIFO:
  - First-word-fall-through; a note pushed at cycle t gives NOTE_VALID=1 at t+1.
  - Pop on NOTE_VALID & NOTE_READY.
  - NOTE_INS and NOTE_BPM are stable while NOTE_VALID & !NOTE_READY.
  - Push and pop in the same cycle on a non-full FIFO leave the count unchanged.
- PAUSE does not affect FIFO draining; the consumer applies its own pause.
- Reset asserted mid-fetch drops MEM_REQ immediately. A late MEM_ACK after reset is ignored in IDLE.
- REP_LEVEL=sp, updated in the cycle after DECODE.

Test Plan:
- Linear play: memory at 0xFF00 holds {0x8123, 0x8456, 0x0000}, NOTE_READY=1, MEM_ACK one cycle after MEM_REQ.
  → NOTE_INS 0x8123 then 0x8456, both with NOTE_BPM=96; DONE=1; addresses 0xFF00–0xFF02 each fetched once.
- BPM + nested repeat: {0x1078, 0x2002, 0x2003, 0x8001, 0x3000, 0x8002, 0x3000, 0x0000}.
  → note sequence (1,1,1,2)×2 = 8 notes, all with NOTE_BPM=120; max REP_LEVEL=2; ends at REP_LEVEL=0, DONE=1.
- Overflow: REP_DEPTH=2, three nested 0x2002 → ERR_OVF=1, no further MEM_REQ, DONE once the FIFO drains.
- Underflow: {0x8001, 0x3000} → one note emitted, then ERR_UNF=1, DONE=1. A following START clears both ERR bits.
- Backpressure: NOTE_READY=0 with 6 notes in memory → exactly FIFO_DEPTH=4 pushes, MEM_REQ stays low while DECODE holds the 5th note. Releasing NOTE_READY delivers all 6 in order with no loss or duplication.
- PAUSE and reset: PAUSE raised while MEM_REQ=1 → request held until MEM_ACK, then no new MEM_REQ until PAUSE=0. RESET_N low mid-repeat → all outputs 0 within the same cycle; START then replays from 0xFF00 with sp=0.
